// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - shares one single-port synchronous RAM between fetch and data ports
//
// Purpose:
//   Arbitrates the instruction-fetch and load/store ports of the core onto one
//   unified single-port synchronous RAM. The RAM accepts one access per cycle.
//   Read data is routed back to the port that issued the read. stallreq_o tells
//   the pipeline that a request is waiting. The data port normally wins. A run
//   counter caps how many data grants in a row can go by while a fetch waits.
//
// Ports:
//   clk, rst                 clock; asynchronous reset, active-low
//   if_req_i / if_addr_i     fetch request (read only) and its address
//   if_gnt_o                 fetch accepted this cycle
//   if_rvalid_o / if_rdata_o fetched word, one cycle after the grant
//   dm_req_i / dm_we_i       data request; 1 = write, 0 = read
//   dm_addr_i / dm_wdata_i   data address and write data
//   dm_sel_i                 byte enables
//   dm_gnt_o                 data accepted this cycle
//   dm_rvalid_o / dm_rdata_o load data, one cycle after a read grant
//   stallreq_o               some request is waiting this cycle
//   mem_ce_o .. mem_sel_o    RAM command, driven by the granted port
//   mem_rdata_i              RAM read data, valid one cycle after ce & ~we

module imem_dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,

  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  input  logic [DATA_W/8-1:0] dm_sel_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,

  output logic                stallreq_o,

  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_DM   = 2'd2
  } rsp_e;

  rsp_e             rsp_q, rsp_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             if_gnt, dm_gnt;

  // Grant decision. Gating with rst keeps every grant, stall and mem_* output
  // at 0 while reset is asserted, even though the request inputs stay live.
  always_comb begin
    dm_gnt = rst & dm_req_i & ((run_cnt_q < RUN_MAX) | ~if_req_i);
    if_gnt = rst & if_req_i & ~dm_gnt;
  end

  assign if_gnt_o   = if_gnt;
  assign dm_gnt_o   = dm_gnt;
  assign stallreq_o = rst & ((if_req_i & ~if_gnt) | (dm_req_i & ~dm_gnt));

  // Memory command mux. Fetch is always a full-word read.
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_sel_o   = '0;
    if (dm_gnt) begin
      mem_ce_o    = 1'b1;
      mem_we_o    = dm_we_i;
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
      mem_sel_o   = dm_sel_i;
    end else if (if_gnt) begin
      mem_ce_o    = 1'b1;
      mem_addr_o  = if_addr_i;
      mem_sel_o   = {SEL_W{1'b1}};
    end
  end

  // Run counter counts data grants that went ahead of a waiting fetch.
  // Any cycle without a fetch request, or a fetch grant, starts a new run.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (!if_req_i || if_gnt) begin
      run_cnt_d = '0;
    end else if (dm_gnt && run_cnt_q != RUN_MAX) begin
      run_cnt_d = run_cnt_q + CNT_W'(1);
    end
  end

  // Next owner of the RAM read port. Recomputed every cycle, so back-to-back
  // reads pipeline without a bubble.
  always_comb begin
    rsp_d = RSP_NONE;
    if (if_gnt) begin
      rsp_d = RSP_IF;
    end else if (dm_gnt && !dm_we_i) begin
      rsp_d = RSP_DM;
    end
  end

  // Reset drops any read in flight: the owner returns to RSP_NONE, so no
  // rvalid appears after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_q     <= RSP_NONE;
      run_cnt_q <= '0;
    end else begin
      rsp_q     <= rsp_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Response routing; the non-owner port sees zero data.
  always_comb begin
    if_rvalid_o = (rsp_q == RSP_IF);
    dm_rvalid_o = (rsp_q == RSP_DM);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - vector-table bench for imem_dmem_arbiter

module tb_imem_dmem_arbiter;

  localparam logic [31:0] M = 32'hA000_0000;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_sel;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_stall;
    logic        e_ce;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_sel;
    logic [31:0] e_wdata;
    logic        e_if_rv;
    logic [31:0] e_if_rdata;
    logic        e_dm_rv;
    logic [31:0] e_dm_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic [3:0]  dm_sel_i = '0;

  // Instance a: MAX_DATA_RUN = 4
  logic        if_gnt_a, if_rvalid_a, dm_gnt_a, dm_rvalid_a, stall_a, ce_a, we_a;
  logic [31:0] if_rdata_a, dm_rdata_a, addr_a, wdata_a, rdata_a;
  logic [3:0]  sel_a;
  // Instance b: MAX_DATA_RUN = 1
  logic        if_gnt_b, if_rvalid_b, dm_gnt_b, dm_rvalid_b, stall_b, ce_b, we_b;
  logic [31:0] if_rdata_b, dm_rdata_b, addr_b, wdata_b, rdata_b;
  logic [3:0]  sel_b;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_a),
    .if_rvalid_o(if_rvalid_a), .if_rdata_o(if_rdata_a),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_sel_i(dm_sel_i), .dm_gnt_o(dm_gnt_a),
    .dm_rvalid_o(dm_rvalid_a), .dm_rdata_o(dm_rdata_a),
    .stallreq_o(stall_a),
    .mem_ce_o(ce_a), .mem_we_o(we_a), .mem_addr_o(addr_a),
    .mem_wdata_o(wdata_a), .mem_sel_o(sel_a), .mem_rdata_i(rdata_a)
  );

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(1)) dut_b (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_b),
    .if_rvalid_o(if_rvalid_b), .if_rdata_o(if_rdata_b),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_sel_i(dm_sel_i), .dm_gnt_o(dm_gnt_b),
    .dm_rvalid_o(dm_rvalid_b), .dm_rdata_o(dm_rdata_b),
    .stallreq_o(stall_b),
    .mem_ce_o(ce_b), .mem_we_o(we_b), .mem_addr_o(addr_b),
    .mem_wdata_o(wdata_b), .mem_sel_o(sel_b), .mem_rdata_i(rdata_b)
  );

  // Behavioural single-port synchronous RAMs, one per instance.
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = M | 32'(i);
      mem_b[i] = M | 32'(i);
    end
    rdata_a = '0;
    rdata_b = '0;
  end

  always @(posedge clk) begin
    if (ce_a && !we_a) rdata_a <= mem_a[addr_a[7:2]];
    if (ce_a && we_a)
      for (int b = 0; b < 4; b++)
        if (sel_a[b]) mem_a[addr_a[7:2]][8*b +: 8] <= wdata_a[8*b +: 8];
    if (ce_b && !we_b) rdata_b <= mem_b[addr_b[7:2]];
    if (ce_b && we_b)
      for (int b = 0; b < 4; b++)
        if (sel_b[b]) mem_b[addr_b[7:2]][8*b +: 8] <= wdata_b[8*b +: 8];
  end

  function automatic vec_t v(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
    input logic [3:0] ds,
    input logic eig, input logic edg, input logic est, input logic ece, input logic ewe,
    input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ewd,
    input logic eirv, input logic [31:0] eird, input logic edrv, input logic [31:0] edrd);
    vec_t t;
    t.if_req = ir;    t.if_addr = ia;
    t.dm_req = dr;    t.dm_we = dw;     t.dm_addr = da;
    t.dm_wdata = dwd; t.dm_sel = ds;
    t.e_if_gnt = eig; t.e_dm_gnt = edg; t.e_stall = est;
    t.e_ce = ece;     t.e_we = ewe;     t.e_addr = ea;
    t.e_sel = es;     t.e_wdata = ewd;
    t.e_if_rv = eirv; t.e_if_rdata = eird;
    t.e_dm_rv = edrv; t.e_dm_rdata = edrd;
    return t;
  endfunction

  function automatic logic [138:0] exp_bits(input vec_t t);
    return {t.e_if_gnt, t.e_dm_gnt, t.e_stall, t.e_ce, t.e_we, t.e_addr, t.e_sel,
            t.e_wdata, t.e_if_rv, t.e_if_rdata, t.e_dm_rv, t.e_dm_rdata};
  endfunction

  // Write data is a don't-care on a fetch grant, so it is masked there.
  function automatic logic [138:0] got_bits(input int which, input vec_t t);
    if (which == 0)
      return {if_gnt_a, dm_gnt_a, stall_a, ce_a, we_a, addr_a, sel_a,
              (t.e_if_gnt ? 32'h0 : wdata_a),
              if_rvalid_a, if_rdata_a, dm_rvalid_a, dm_rdata_a};
    else
      return {if_gnt_b, dm_gnt_b, stall_b, ce_b, we_b, addr_b, sel_b,
              (t.e_if_gnt ? 32'h0 : wdata_b),
              if_rvalid_b, if_rdata_b, dm_rvalid_b, dm_rdata_b};
  endfunction

  task automatic run_vec(input string name, input int idx, input int which, input vec_t t);
    logic [138:0] g, e;
    if_req_i   = t.if_req;
    if_addr_i  = t.if_addr;
    dm_req_i   = t.dm_req;
    dm_we_i    = t.dm_we;
    dm_addr_i  = t.dm_addr;
    dm_wdata_i = t.dm_wdata;
    dm_sel_i   = t.dm_sel;
    #2;
    g = got_bits(which, t);
    e = exp_bits(t);
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s[%0d] got=%h exp=%h (gnt_if,gnt_dm,stall,ce,we,addr,sel,wdata,if_rv,if_rd,dm_rv,dm_rd)",
               name, idx, g, e);
    end
  endtask

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  vec_t z;

  initial begin
    z = v(0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0);

    // Instance a: idle after reset release, fetch stream, contention, write.
    tbl_a.push_back(v(0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0, 1,M|32'h0));
    tbl_a.push_back(v(1,32'h0, 0,0,0,0,0, 1,0,0,1,0,32'h0,4'hF,0, 0,0,0,0));
    tbl_a.push_back(v(1,32'h4, 0,0,0,0,0, 1,0,0,1,0,32'h4,4'hF,0, 1,M|32'h0,0,0));
    tbl_a.push_back(v(1,32'h8, 0,0,0,0,0, 1,0,0,1,0,32'h8,4'hF,0, 1,M|32'h1,0,0));
    tbl_a.push_back(v(0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0, 1,M|32'h2,0,0));
    tbl_a.push_back(z);
    tbl_a.push_back(v(1,32'h20, 1,0,32'h40,0,4'hF, 0,1,1,1,0,32'h40,4'hF,0, 0,0,0,0));
    tbl_a.push_back(v(1,32'h20, 1,0,32'h44,0,4'hF, 0,1,1,1,0,32'h44,4'hF,0, 0,0,1,M|32'h10));
    tbl_a.push_back(v(1,32'h20, 1,0,32'h48,0,4'hF, 0,1,1,1,0,32'h48,4'hF,0, 0,0,1,M|32'h11));
    tbl_a.push_back(v(1,32'h20, 1,0,32'h4C,0,4'hF, 0,1,1,1,0,32'h4C,4'hF,0, 0,0,1,M|32'h12));
    tbl_a.push_back(v(1,32'h20, 1,0,32'h50,0,4'hF, 1,0,1,1,0,32'h20,4'hF,0, 0,0,1,M|32'h13));
    tbl_a.push_back(v(1,32'h20, 1,0,32'h50,0,4'hF, 0,1,1,1,0,32'h50,4'hF,0, 1,M|32'h8,0,0));
    tbl_a.push_back(v(1,32'h20, 0,0,0,0,0, 1,0,0,1,0,32'h20,4'hF,0, 0,0,1,M|32'h14));
    tbl_a.push_back(v(0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0, 1,M|32'h8,0,0));
    tbl_a.push_back(v(0,0, 1,1,32'h10,32'hDEADBEEF,4'b0011,
                      0,1,0,1,1,32'h10,4'b0011,32'hDEADBEEF, 0,0,0,0));
    tbl_a.push_back(v(0,0, 1,0,32'h10,0,4'hF, 0,1,0,1,0,32'h10,4'hF,0, 0,0,0,0));
    tbl_a.push_back(v(0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,1,32'hA000BEEF));
    tbl_a.push_back(z);

    // Instance b: strict alternation under contention.
    tbl_b.push_back(v(1,32'h20, 1,0,32'h40,0,4'hF, 0,1,1,1,0,32'h40,4'hF,0, 0,0,0,0));
    tbl_b.push_back(v(1,32'h20, 1,0,32'h44,0,4'hF, 1,0,1,1,0,32'h20,4'hF,0, 0,0,1,M|32'h10));
    tbl_b.push_back(v(1,32'h20, 1,0,32'h44,0,4'hF, 0,1,1,1,0,32'h44,4'hF,0, 1,M|32'h8,0,0));
    tbl_b.push_back(v(1,32'h20, 1,0,32'h48,0,4'hF, 1,0,1,1,0,32'h20,4'hF,0, 0,0,1,M|32'h11));
    tbl_b.push_back(v(0,0, 1,0,32'h48,0,4'hF, 0,1,0,1,0,32'h48,4'hF,0, 1,M|32'h8,0,0));
    tbl_b.push_back(v(0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,1,M|32'h12));

    // Reset held with both requests active: everything must read 0.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_vec("rst_hold_a", 0, 0, v(1,0, 1,0,0,0,4'hF, 0,0,0,0,0,0,0,0, 0,0,0,0));
    run_vec("rst_hold_b", 0, 1, v(1,0, 1,0,0,0,4'hF, 0,0,0,0,0,0,0,0, 0,0,0,0));

    // Release: data wins the first cycle.
    @(negedge clk);
    rst = 1'b1;
    run_vec("rst_release", 0, 0, v(1,0, 1,0,0,0,4'hF, 0,1,1,1,0,0,4'hF,0, 0,0,0,0));

    foreach (tbl_a[i]) begin
      @(negedge clk);
      run_vec("tbl_a", i, 0, tbl_a[i]);
    end

    // Read granted, then reset pulsed inside the response cycle.
    @(negedge clk);
    run_vec("rst_inflight_gnt", 0, 0, v(0,0, 1,0,32'h44,0,4'hF, 0,1,0,1,0,32'h44,4'hF,0, 0,0,0,0));
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    run_vec("rst_inflight_drop", 0, 0, v(0,0, 1,0,32'h44,0,4'hF, 0,0,0,0,0,0,0,0, 0,0,0,0));
    @(negedge clk);
    run_vec("rst_inflight_hold", 0, 0, z);
    @(negedge clk);
    rst = 1'b1;
    run_vec("rst_inflight_rel", 0, 0, z);
    @(negedge clk);
    run_vec("rst_inflight_after", 0, 0, z);

    foreach (tbl_b[i]) begin
      @(negedge clk);
      run_vec("tbl_b", i, 1, tbl_b[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
